lsu_mem_initiator: RTL and testbench

//  Load/store initiator between the execute stage and the data-memory responder.

---
 rtl/lsu_pkg.sv | 39 +++
 rtl/lsu_lane_extract.sv | 29 ++
 rtl/lsu_mem_initiator.sv | 140 ++++++++++++++
 tb/tb_lsu_mem_initiator.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store initiator.
// Build option: LSU_MISALIGN_TRAP_EN selects trap-on-misalign instead of forced alignment.
package lsu_pkg;

  localparam int XLEN      = 64;
  localparam int BUS_BYTES = 8;

  typedef enum logic [1:0] {WDT8, WDT16, WDT32, WDT64} wdt_e;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;

  function automatic logic [7:0] base_mask(wdt_e w);
    case (w)
      WDT8:    return 8'h01;
      WDT16:   return 8'h03;
      WDT32:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic is_misaligned(wdt_e w, logic [2:0] a);
    case (w)
      WDT16:   return a[0];
      WDT32:   return |a[1:0];
      WDT64:   return |a;
      default: return 1'b0;
    endcase
  endfunction

  // Clears the low log2(size) lane bits so the access sits on its natural boundary.
  function automatic logic [2:0] align_lane(wdt_e w, logic [2:0] a);
    case (w)
      WDT16:   return {a[2:1], 1'b0};
      WDT32:   return {a[2], 2'b00};
      WDT64:   return 3'b000;
      default: return a;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_extract.sv
// Combinational load-data extraction: shifts the addressed lane down and
// sign- or zero-extends the field selected by the access width.
module lsu_lane_extract
  import lsu_pkg::*;
#(
  parameter int XLEN_P = 64
) (
  input  logic [XLEN_P-1:0] rdata_i,
  input  logic [2:0]        lane_i,
  input  wdt_e              wdt_i,
  input  logic              signed_i,
  output logic [XLEN_P-1:0] result_o
);

  logic [XLEN_P-1:0] shifted;

  assign shifted = rdata_i >> {lane_i, 3'b000};

  always_comb begin
    result_o = shifted;
    case (wdt_i)
      WDT8:    result_o = {{(XLEN_P-8){signed_i & shifted[7]}},   shifted[7:0]};
      WDT16:   result_o = {{(XLEN_P-16){signed_i & shifted[15]}}, shifted[15:0]};
      WDT32:   result_o = {{(XLEN_P-32){signed_i & shifted[31]}}, shifted[31:0]};
      default: result_o = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_initiator.sv
// Single-outstanding load/store initiator: latches an EX request, drives one aligned
// bus request, extends the response for WB. Option: LSU_MISALIGN_TRAP_EN.
module lsu_mem_initiator
  import lsu_pkg::*;
#(
  parameter int XLEN_P      = XLEN,
  parameter int BUS_BYTES_P = BUS_BYTES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic                   in_store_i,
  input  logic [1:0]             in_wdt_i,
  input  logic                   in_signed_i,
  input  logic [XLEN_P-1:0]      in_addr_i,
  input  logic [XLEN_P-1:0]      in_wdata_i,
  output logic                   mem_req_valid_o,
  input  logic                   mem_req_ready_i,
  output logic                   mem_req_wen_o,
  output logic [XLEN_P-1:0]      mem_req_addr_o,
  output logic [XLEN_P-1:0]      mem_req_wdata_o,
  output logic [BUS_BYTES_P-1:0] mem_req_wmask_o,
  input  logic                   mem_rsp_valid_i,
  input  logic [XLEN_P-1:0]      mem_rsp_rdata_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [XLEN_P-1:0]      out_rdata_o,
  output logic                   out_misalign_o
);

  state_e            state_q, state_d;
  logic              store_q, store_d;
  wdt_e              wdt_q, wdt_d;
  logic              signed_q, signed_d;
  logic [XLEN_P-1:0] addr_q, addr_d;
  logic [XLEN_P-1:0] wdata_q, wdata_d;
  logic [XLEN_P-1:0] result_q, result_d;
  logic              misalign_q, misalign_d;

  logic              trap_now;
  logic              req_active;
  logic [2:0]        lane;
  logic [XLEN_P-1:0] load_data;

  // Aligned accesses are unaffected by align_lane, so one lane path serves both builds.
  assign lane = align_lane(wdt_q, addr_q[2:0]);

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap_now = is_misaligned(wdt_q, addr_q[2:0]);
`else
  assign trap_now = 1'b0;
`endif

  lsu_lane_extract #(.XLEN_P(XLEN_P)) u_extract (
    .rdata_i  (mem_rsp_rdata_i),
    .lane_i   (lane),
    .wdt_i    (wdt_q),
    .signed_i (signed_q),
    .result_o (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      store_q    <= 1'b0;
      wdt_q      <= WDT8;
      signed_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      result_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      store_q    <= store_d;
      wdt_q      <= wdt_d;
      signed_q   <= signed_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      result_q   <= result_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    store_d    = store_q;
    wdt_d      = wdt_q;
    signed_d   = signed_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    result_d   = result_q;
    misalign_d = misalign_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          store_d    = in_store_i;
          wdt_d      = wdt_e'(in_wdt_i);
          signed_d   = in_signed_i;
          addr_d     = in_addr_i;
          wdata_d    = in_wdata_i;
          misalign_d = 1'b0;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (trap_now) begin
          misalign_d = 1'b1;
          result_d   = '0;
          state_d    = DONE;
        end else if (mem_req_ready_i) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Stores only receive a write ack, so their result is forced to zero.
        if (mem_rsp_valid_i) begin
          result_d = store_q ? '0 : load_data;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_active      = (state_q == REQ) && !trap_now;
  assign in_ready_o      = (state_q == IDLE);
  assign mem_req_valid_o = req_active;
  assign mem_req_wen_o   = req_active & store_q;
  assign mem_req_addr_o  = req_active ? {addr_q[XLEN_P-1:3], 3'b000} : '0;
  assign mem_req_wdata_o = req_active ? (wdata_q << {lane, 3'b000}) : '0;
  assign mem_req_wmask_o = (req_active && store_q) ? BUS_BYTES_P'(base_mask(wdt_q) << lane) : '0;
  assign out_valid_o     = (state_q == DONE);
  assign out_rdata_o     = result_q;
  assign out_misalign_o  = misalign_q;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Directed-vector bench for lsu_mem_initiator with a scripted bus responder.
module tb_lsu_mem_initiator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_store = 1'b0, in_signed = 1'b0;
  logic [1:0]  in_wdt = 2'd0;
  logic [63:0] in_addr = '0, in_wdata = '0;
  logic        in_ready;
  logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_wen;
  logic [63:0] mem_req_addr, mem_req_wdata;
  logic [7:0]  mem_req_wmask;
  logic        mem_rsp_valid = 1'b0;
  logic [63:0] mem_rsp_rdata = '0;
  logic        out_valid, out_ready = 1'b0, out_misalign;
  logic [63:0] out_rdata;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lsu_mem_initiator dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .in_valid_i      (in_valid),
    .in_ready_o      (in_ready),
    .in_store_i      (in_store),
    .in_wdt_i        (in_wdt),
    .in_signed_i     (in_signed),
    .in_addr_i       (in_addr),
    .in_wdata_i      (in_wdata),
    .mem_req_valid_o (mem_req_valid),
    .mem_req_ready_i (mem_req_ready),
    .mem_req_wen_o   (mem_req_wen),
    .mem_req_addr_o  (mem_req_addr),
    .mem_req_wdata_o (mem_req_wdata),
    .mem_req_wmask_o (mem_req_wmask),
    .mem_rsp_valid_i (mem_rsp_valid),
    .mem_rsp_rdata_i (mem_rsp_rdata),
    .out_valid_o     (out_valid),
    .out_ready_i     (out_ready),
    .out_rdata_o     (out_rdata),
    .out_misalign_o  (out_misalign)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: rs = request-ready stall cycles, os = out-ready stall cycles.
  task automatic txn(input string nm, input logic st, input logic [1:0] w, input logic sg,
                     input logic [63:0] ad, input logic [63:0] wd, input logic [63:0] rd,
                     input int rs, input int os,
                     input logic [63:0] e_addr, input logic [63:0] e_wd, input logic [7:0] e_mask,
                     input logic [63:0] e_out, input logic e_mis);
    int t0;
    check_val({nm, ".in_ready"}, {63'd0, in_ready}, 64'd1);
    in_valid = 1'b1; in_store = st; in_wdt = w; in_signed = sg; in_addr = ad; in_wdata = wd;
    t0 = cyc;
    step();
    in_valid = 1'b0; in_addr = '0; in_wdata = '0;
    if (e_mis) begin
      check_val({nm, ".no_req"}, {63'd0, mem_req_valid}, 64'd0);
      step();
    end else begin
      for (int i = 0; i <= rs; i++) begin
        check_val({nm, ".req_valid"}, {63'd0, mem_req_valid}, 64'd1);
        check_val({nm, ".req_addr"},  mem_req_addr, e_addr);
        check_val({nm, ".req_wdata"}, mem_req_wdata, e_wd);
        check_val({nm, ".req_wmask"}, {56'd0, mem_req_wmask}, {56'd0, e_mask});
        check_val({nm, ".req_wen"},   {63'd0, mem_req_wen}, {63'd0, st});
        if (i == rs) mem_req_ready = 1'b1;
        step();
      end
      mem_req_ready = 1'b0;
      check_val({nm, ".req_drop"}, {63'd0, mem_req_valid}, 64'd0);
      mem_rsp_valid = 1'b1; mem_rsp_rdata = rd;
      step();
      mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    end
    if (rs == 0 && !e_mis) check_val({nm, ".latency"}, 64'(cyc - t0), 64'd3);
    for (int i = 0; i <= os; i++) begin
      check_val({nm, ".out_valid"}, {63'd0, out_valid}, 64'd1);
      check_val({nm, ".out_rdata"}, out_rdata, e_out);
      check_val({nm, ".out_mis"},   {63'd0, out_misalign}, {63'd0, e_mis});
      check_val({nm, ".busy"},      {63'd0, in_ready}, 64'd0);
      if (i == os) out_ready = 1'b1;
      step();
    end
    out_ready = 1'b0;
    check_val({nm, ".out_drop"}, {63'd0, out_valid}, 64'd0);
    $display("txn %s: addr=0x%016h result=0x%016h mis=%0d", nm, ad, e_out, e_mis);
  endtask

  initial begin
    #12;
    check_val("rst.in_ready",  {63'd0, in_ready}, 64'd1);
    check_val("rst.req_valid", {63'd0, mem_req_valid}, 64'd0);
    check_val("rst.out_valid", {63'd0, out_valid}, 64'd0);
    check_val("rst.out_rdata", out_rdata, 64'd0);
    check_val("rst.out_mis",   {63'd0, out_misalign}, 64'd0);
    check_val("rst.bus",       mem_req_addr | mem_req_wdata | {56'd0, mem_req_wmask}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    txn("lb_pos", 1'b0, 2'd0, 1'b1, 64'h80000003, 64'h0, 64'h1122334455667788, 0, 0,
        64'h80000000, 64'h0, 8'h00, 64'h0000000000000055, 1'b0);
    txn("lb_neg", 1'b0, 2'd0, 1'b1, 64'h80000003, 64'h0, 64'h1122334485667788, 0, 0,
        64'h80000000, 64'h0, 8'h00, 64'hFFFFFFFFFFFFFF85, 1'b0);
    txn("lbu",    1'b0, 2'd0, 1'b0, 64'h80000003, 64'h0, 64'h1122334485667788, 0, 0,
        64'h80000000, 64'h0, 8'h00, 64'h0000000000000085, 1'b0);
    txn("sh",     1'b1, 2'd1, 1'b0, 64'h80000006, 64'hBEEF, 64'hDEADDEADDEADDEAD, 0, 0,
        64'h80000000, 64'hBEEF000000000000, 8'hC0, 64'h0, 1'b0);
    txn("lwu",    1'b0, 2'd2, 1'b0, 64'h80000004, 64'h0, 64'h8000000000000000, 0, 0,
        64'h80000000, 64'h0, 8'h00, 64'h0000000080000000, 1'b0);
    txn("lh_stl", 1'b0, 2'd1, 1'b1, 64'h10000002, 64'h0, 64'h00000000F00D0000, 5, 0,
        64'h10000000, 64'h0, 8'h00, 64'hFFFFFFFFFFFFF00D, 1'b0);
    txn("sb_ohd", 1'b1, 2'd0, 1'b0, 64'h00000007, 64'hAB, 64'h0123456789ABCDEF, 0, 4,
        64'h00000000, 64'hAB00000000000000, 8'h80, 64'h0, 1'b0);
`ifdef LSU_MISALIGN_TRAP_EN
    txn("ld_mis", 1'b0, 2'd3, 1'b0, 64'h80000004, 64'h0, 64'h0123456789ABCDEF, 0, 0,
        64'h0, 64'h0, 8'h00, 64'h0, 1'b1);
`else
    txn("ld_mis", 1'b0, 2'd3, 1'b0, 64'h80000004, 64'h0, 64'h0123456789ABCDEF, 0, 0,
        64'h80000000, 64'h0, 8'h00, 64'h0123456789ABCDEF, 1'b0);
`endif

    // Abort in WAIT, then a stray response must not produce a result.
    in_valid = 1'b1; in_store = 1'b0; in_wdt = 2'd3; in_signed = 1'b0; in_addr = 64'h40;
    step();
    in_valid = 1'b0;
    mem_req_ready = 1'b1;
    step();
    mem_req_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_val("abort.req_valid", {63'd0, mem_req_valid}, 64'd0);
    check_val("abort.in_ready",  {63'd0, in_ready}, 64'd1);
    check_val("abort.out_valid", {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'hFFFF0000FFFF0000;
    step();
    mem_rsp_valid = 1'b0;
    step();
    check_val("stray.out_valid", {63'd0, out_valid}, 64'd0);
    check_val("stray.in_ready",  {63'd0, in_ready}, 64'd1);
    check_val("stray.out_rdata", out_rdata, 64'd0);
    $display("txn abort: reset in WAIT, stray response ignored");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
